// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and the
// step/counter sizing helpers derived from WIDTH and DIGIT.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return (digit > 0) ? width / digit : 1;
    endfunction

    // A single-step adder still needs a one-bit counter to keep the datapath legal.
    function automatic int calc_cnt_width(input int width, input int digit);
        int w;
        w = $clog2(calc_steps(width, digit));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the per-bit cell of the serial adder digit chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin computed DIGIT bits per cycle, LSB digit
// first, with a start/busy/done handshake and registered results.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = calc_cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     acc;
    logic                 carry;

    logic [DIGIT-1:0]       dsum;
    logic [DIGIT:0]         chain;
    logic [WIDTH+DIGIT-1:0] widened;
    logic [WIDTH-1:0]       accnext;

    assign chain[0] = carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a    (opa[i]),
            .b    (opb[i]),
            .cin  (chain[i]),
            .sum  (dsum[i]),
            .cout (chain[i+1])
        );
    end

    // New digit enters from the MSB side so the LSB digit ends up at bit 0.
    assign widened = {dsum, acc};
    assign accnext = widened[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    acc   <= accnext;
                    carry <= chain[DIGIT];
                    cnt   <= cnt + CW'(1);
                    // On the last step the top cell of the chain is the word's MSB.
                    if (cnt == LAST) begin
                        sum      <= accnext;
                        cout     <= chain[DIGIT];
                        overflow <= chain[DIGIT-1] ^ chain[DIGIT];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across (8,1), (8,4), (2,1) and (2,2)
// configurations; each DUT has its own expectation queue and monitor.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;
    exp_t sb[4][$];

    logic       st81 = 0, ci81 = 0, busy81, done81, co81, ov81;
    logic [7:0] a81 = 0, b81 = 0, sum81;
    logic       st84 = 0, ci84 = 0, busy84, done84, co84, ov84;
    logic [7:0] a84 = 0, b84 = 0, sum84;
    logic       st21 = 0, ci21 = 0, busy21, done21, co21, ov21;
    logic [1:0] a21 = 0, b21 = 0, sum21;
    logic       st22 = 0, ci22 = 0, busy22, done22, co22, ov22;
    logic [1:0] a22 = 0, b22 = 0, sum22;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .rst(rst), .start(st81), .a(a81), .b(b81), .cin(ci81),
        .busy(busy81), .done(done81), .sum(sum81), .cout(co81), .overflow(ov81));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d84 (
        .clk(clk), .rst(rst), .start(st84), .a(a84), .b(b84), .cin(ci84),
        .busy(busy84), .done(done84), .sum(sum84), .cout(co84), .overflow(ov84));
    serial_adder #(.WIDTH(2), .DIGIT(1)) u_d21 (
        .clk(clk), .rst(rst), .start(st21), .a(a21), .b(b21), .cin(ci21),
        .busy(busy21), .done(done21), .sum(sum21), .cout(co21), .overflow(ov21));
    serial_adder #(.WIDTH(2), .DIGIT(2)) u_d22 (
        .clk(clk), .rst(rst), .start(st22), .a(a22), .b(b22), .cin(ci22),
        .busy(busy22), .done(done22), .sum(sum22), .cout(co22), .overflow(ov22));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic monitorPop(input int sel, input logic [7:0] s, input logic co, input logic ov);
        exp_t e;
        if (sb[sel].size() == 0) begin
            nvec++;
            nmis++;
            $display("[TB] FAIL unexpected_done dut%0d: got done=1, expected none (cycle %0d)", sel, cyc);
        end else begin
            e = sb[sel].pop_front();
            checkOutput($sformatf("dut%0d_sum", sel), 32'(s), 32'(e.sum));
            checkOutput($sformatf("dut%0d_cout", sel), 32'(co), 32'(e.cout));
            checkOutput($sformatf("dut%0d_overflow", sel), 32'(ov), 32'(e.ovf));
            checkOutput($sformatf("dut%0d_done_cycle", sel), 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) if (done81 === 1'b1) monitorPop(0, sum81, co81, ov81);
    always @(negedge clk) if (done84 === 1'b1) monitorPop(1, sum84, co84, ov84);
    always @(negedge clk) if (done21 === 1'b1) monitorPop(2, {6'b0, sum21}, co21, ov21);
    always @(negedge clk) if (done22 === 1'b1) monitorPop(3, {6'b0, sum22}, co22, ov22);

    // Called at a falling edge; start is taken at the next rising edge.
    task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv,
                                 input logic ci, input logic [7:0] es, input logic ec,
                                 input logic eo);
        exp_t e;
        int   steps;
        case (sel)
            0: steps = 8;
            1: steps = 2;
            2: steps = 2;
            default: steps = 1;
        endcase
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.cyc  = cyc + 1 + steps;
        sb[sel].push_back(e);
        case (sel)
            0: begin a81 = av; b81 = bv; ci81 = ci; st81 = 1'b1; end
            1: begin a84 = av; b84 = bv; ci84 = ci; st84 = 1'b1; end
            2: begin a21 = av[1:0]; b21 = bv[1:0]; ci21 = ci; st21 = 1'b1; end
            default: begin a22 = av[1:0]; b22 = bv[1:0]; ci22 = ci; st22 = 1'b1; end
        endcase
        @(negedge clk);
        st81 = 1'b0; st84 = 1'b0; st21 = 1'b0; st22 = 1'b0;
    endtask

    task automatic waitIdle(input int sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb[sel].size() == 0) return;
            @(negedge clk);
        end
        nvec++;
        nmis++;
        $display("[TB] FAIL timeout dut%0d: got %0d pending results, expected 0", sel, sb[sel].size());
        sb[sel].delete();
    endtask

    function automatic exp_t model2(input int av, input int bv, input int ci);
        exp_t e;
        int   full, sa, sbv, ss;
        full  = av + bv + ci;
        sa    = (av >= 2) ? av - 4 : av;
        sbv   = (bv >= 2) ? bv - 4 : bv;
        ss    = sa + sbv + ci;
        e.sum  = 8'(full % 4);
        e.cout = (full >= 4);
        e.ovf  = (ss > 1) || (ss < -2);
        e.cyc  = 0;
        return e;
    endfunction

    initial begin
        exp_t m;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 32'(busy81), 0);
        checkOutput("reset_done", 32'(done81), 0);
        checkOutput("reset_sum", 32'(sum81), 0);
        checkOutput("reset_cout", 32'(co81), 0);
        checkOutput("reset_overflow", 32'(ov81), 0);
        @(negedge clk);

        applyStimulus(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        waitIdle(0, 20);
        applyStimulus(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        waitIdle(0, 20);
        applyStimulus(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        checkOutput("busy_mid_run", 32'(busy81), 1);
        checkOutput("sum_held_while_busy", 32'(sum81), 32'h00);
        waitIdle(0, 20);

        // Starts and operand changes during RUN must not disturb the result.
        applyStimulus(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        a81 = 8'hFF; b81 = 8'hFF; ci81 = 1'b1; st81 = 1'b1;
        @(negedge clk);
        st81 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a81 = 8'h55; b81 = 8'hAA; st81 = 1'b1;
        @(negedge clk);
        st81 = 1'b0;
        waitIdle(0, 20);
        repeat (4) @(negedge clk);

        applyStimulus(1, 8'h96, 8'h5A, 1'b1, 8'hF1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        waitIdle(1, 10);

        a81 = 8'h11; b81 = 8'h22; ci81 = 1'b0; st81 = 1'b1;
        @(negedge clk);
        st81 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy81), 0);
        checkOutput("abort_done", 32'(done81), 0);
        checkOutput("abort_sum", 32'(sum81), 0);
        checkOutput("abort_cout", 32'(co81), 0);
        checkOutput("abort_overflow", 32'(ov81), 0);
        repeat (12) @(negedge clk);
        applyStimulus(0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);
        waitIdle(0, 20);

        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    m = model2(av, bv, ci);
                    applyStimulus(2, 8'(av), 8'(bv), 1'(ci), m.sum, m.cout, m.ovf);
                    waitIdle(2, 10);
                    applyStimulus(3, 8'(av), 8'(bv), 1'(ci), m.sum, m.cout, m.ovf);
                    waitIdle(3, 10);
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
